fp_minmax_scan: RTL

FP_MINMAX_SCAN -- requirements
Module: fp_minmax_scan

---
 rtl/fp_minmax_scan.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fp_minmax_scan.sv
// ---------------------------------------------------------------------------
// fp_minmax_scan : streaming min/max scan over IEEE-754 single-precision
// frames, reporting largest/smallest value, their beat indices and the beat
// count. Optional macro FP_MINMAX_SIGN_AWARE_EN selects signed numeric
// ordering; otherwise ordering is by magnitude only.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_minmax_scan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_large,
  output logic [31:0]      out_small,
  output logic [CNT_W-1:0] out_large_idx,
  output logic [CNT_W-1:0] out_small_idx,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_large;
  logic [31:0]      r_small;
  logic [CNT_W-1:0] r_large_idx;
  logic [CNT_W-1:0] r_small_idx;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic [31:0]      w_key_in;
  logic [31:0]      w_key_large;
  logic [31:0]      w_key_small;
  logic             w_gt;
  logic             w_lt;

  // Map an operand to an unsigned key whose integer order is the desired
  // float order, so a single unsigned compare does the work.
  function automatic logic [31:0] f_key(input logic [31:0] x);
`ifdef FP_MINMAX_SIGN_AWARE_EN
    if (x[30:0] == 31'd0) begin
      f_key = 32'h8000_0000;
    end else if (x[31]) begin
      f_key = ~x;
    end else begin
      f_key = x | 32'h8000_0000;
    end
`else
    f_key = {1'b0, x[30:0]};
`endif
  endfunction

  assign w_key_in    = f_key(in_data);
  assign w_key_large = f_key(r_large);
  assign w_key_small = f_key(r_small);
  assign w_gt        = w_key_in > w_key_large;
  assign w_lt        = w_key_in < w_key_small;
  assign w_accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = in_last ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Results persist across IDLE so the previous frame stays observable
  // until the next frame's first beat overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_large     <= 32'd0;
      r_small     <= 32'd0;
      r_large_idx <= '0;
      r_small_idx <= '0;
      r_count     <= '0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_large     <= in_data;
        r_small     <= in_data;
        r_large_idx <= '0;
        r_small_idx <= '0;
        r_count     <= C_CNT_ONE;
      end else begin
        if (w_gt) begin
          r_large     <= in_data;
          r_large_idx <= r_count;
        end
        if (w_lt) begin
          r_small     <= in_data;
          r_small_idx <= r_count;
        end
        if (r_count != C_CNT_MAX) begin
          r_count <= r_count + C_CNT_ONE;
        end
      end
    end
  end

  assign out_large     = r_large;
  assign out_small     = r_small;
  assign out_large_idx = r_large_idx;
  assign out_small_idx = r_small_idx;
  assign out_count     = r_count;

endmodule

`default_nettype wire
